// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared block type, word-per-block constant and issue-FSM states
package aes_pkg;

  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 4;
  localparam int BLK_W         = WORD_W * WORDS_PER_BLK;

  typedef logic [BLK_W-1:0] aes_block_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } issue_state_t;

  function automatic logic [WORD_W-1:0] byte_rev32(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mod_blkfifo.sv
// rtl/mod_blkfifo.sv - circular store of DEPTH 128-bit blocks with count, full and empty
module mod_blkfifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  aes_block_t       i_push_data,
  input  logic             i_pop,
  output aes_block_t       o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  aes_block_t       r_slots [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_slots[r_rd_ptr];
  // A push into a full store is legal when the head leaves on the same edge.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_slots[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/aes_in_packer.sv
// rtl/aes_in_packer.sv - packs 32-bit stream words into 128-bit blocks and issues them to the AES encoder
// Define AES_PACK_BYTESWAP_EN to byte-reverse each word as it is captured.
module aes_in_packer
  import aes_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [31:0]  s_tdata,
  input  logic         s_tvalid,
  input  logic         s_tlast,
  output logic         s_tready,
  output logic [127:0] enc_dataIn,
  output logic         ctrl_dataIn_enc,
  input  logic         ctrl_dataOut_enc,
  output logic         busy,
  output logic         err_frame
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic                      r_rdy_en;
  logic [1:0]                r_wcnt;
  logic [3*WORD_W-1:0]       r_asm;
  logic                      r_err;
  issue_state_t              r_state;
  aes_block_t                r_enc_data;
  logic                      r_start;
  logic                      r_busy;

  logic [WORD_W-1:0]         w_word;
  logic                      w_xfer;
  logic                      w_last_word;
  logic                      w_short;
  logic                      w_push;
  logic                      w_pop;
  aes_block_t                w_push_blk;
  aes_block_t                w_head;
  logic [CNT_W-1:0]          w_count;
  logic                      w_full;
  logic                      w_empty;

`ifdef AES_PACK_BYTESWAP_EN
  assign w_word = byte_rev32(s_tdata);
`else
  assign w_word = s_tdata;
`endif

  assign w_xfer      = s_tvalid && s_tready;
  assign w_last_word = (r_wcnt == 2'(WORDS_PER_BLK - 1));
  assign w_short     = w_xfer && s_tlast && !w_last_word;
  assign w_push      = w_xfer && w_last_word;
  assign w_push_blk  = {w_word, r_asm};
  assign w_pop       = (r_state == ST_BUSY) && ctrl_dataOut_enc && (w_count != '0);
  // Ready looks through a same-cycle pop so the stream never loses a cycle on a full store.
  assign s_tready    = r_rdy_en && (!w_full || w_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdy_en <= 1'b0;
      r_wcnt   <= '0;
      r_asm    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_short) begin
        r_wcnt <= '0;
        r_err  <= 1'b1;
      end else if (w_xfer) begin
        case (r_wcnt)
          2'd0:    r_asm[31:0]  <= w_word;
          2'd1:    r_asm[63:32] <= w_word;
          2'd2:    r_asm[95:64] <= w_word;
          default: r_asm        <= r_asm;
        endcase
        r_wcnt <= r_wcnt + 2'd1;
      end
    end
  end

  // The head block is latched on the way into START and held until the next issue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_enc_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state    <= ST_START;
            r_start    <= 1'b1;
            r_busy     <= 1'b1;
            r_enc_data <= w_head;
          end
        end
        ST_START: begin
          r_state <= ST_BUSY;
          r_start <= 1'b0;
        end
        ST_BUSY: begin
          if (ctrl_dataOut_enc) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_start <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign enc_dataIn      = r_enc_data;
  assign ctrl_dataIn_enc = r_start;
  assign busy            = r_busy;
  assign err_frame       = r_err;

  mod_blkfifo #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_blkfifo (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (w_push),
    .i_push_data (w_push_blk),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

endmodule

// File: tb/tb_aes_in_packer.sv
// tb/tb_aes_in_packer.sv - scoreboard bench for aes_in_packer with a queue-based packing model
`timescale 1ns/1ps
module tb_aes_in_packer;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic [31:0]  s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tlast = 1'b0;
  logic         s_tready;
  logic [127:0] enc_dataIn;
  logic         ctrl_dataIn_enc;
  logic         ctrl_dataOut_enc;
  logic         busy;
  logic         err_frame;

  logic         man_done = 1'b0;
  logic         auto_done = 1'b0;
  bit           auto_en = 1'b0;
  assign ctrl_dataOut_enc = man_done | auto_done;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [31:0]  m_words[$];
  logic [127:0] exp_q[$];
  logic         m_err = 1'b0;
  logic [127:0] held = '0;
  int           dly;

  aes_in_packer #(.BUF_DEPTH(2)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .s_tdata          (s_tdata),
    .s_tvalid         (s_tvalid),
    .s_tlast          (s_tlast),
    .s_tready         (s_tready),
    .enc_dataIn       (enc_dataIn),
    .ctrl_dataIn_enc  (ctrl_dataIn_enc),
    .ctrl_dataOut_enc (ctrl_dataOut_enc),
    .busy             (busy),
    .err_frame        (err_frame)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(string name, string why);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, why);
  endfunction

  // Reference: collect accepted words; four make a block, an early tlast drops the partial.
  function automatic void model_accept(logic [31:0] d, logic last);
    logic [31:0] w;
`ifdef AES_PACK_BYTESWAP_EN
    w = {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    w = d;
`endif
    if (last && m_words.size() != 3) begin
      m_words.delete();
      m_err = 1'b1;
    end else begin
      m_words.push_back(w);
      if (m_words.size() == 4) begin
        exp_q.push_back({m_words[3], m_words[2], m_words[1], m_words[0]});
        m_words.delete();
      end
    end
  endfunction

  task automatic send_word(input logic [31:0] d, input logic last);
    int  waited;
    bit  sent;
    waited = 0;
    sent = 1'b0;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    while (!sent && waited < 200) begin
      @(negedge clk);
      sent = s_tready;
      @(posedge clk);
      if (sent) model_accept(d, last);
      else waited++;
    end
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (!sent) fail_now("send_timeout", "s_tready stayed 0 for 200 cycles, required 1");
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) fail_now("drain_timeout", "blocks still outstanding, required none");
    @(posedge clk);
    #1;
  endtask

  always begin
    @(negedge clk);
    if (auto_en && ctrl_dataIn_enc) begin
      dly = $urandom_range(0, 4);
      repeat (dly + 1) @(posedge clk);
      #1 auto_done = 1'b1;
      @(posedge clk);
      #1 auto_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (ctrl_dataIn_enc) begin
        chk("start_busy", busy, 1);
        if (exp_q.size() == 0) fail_now("start_unexpected", "got a start pulse, required none");
        else chk("block_data", enc_dataIn, exp_q.pop_front());
        held = enc_dataIn;
      end else if (busy) begin
        chk("hold_data", enc_dataIn, held);
      end
    end
  end

  initial begin
    logic [127:0] known;
    int           kind;
    int           len;
`ifdef AES_PACK_BYTESWAP_EN
    known = 128'h0C0D0E0F_08090A0B_04050607_00010203;
`else
    known = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
`endif

    #1 resetn = 1'b0;
    #1;
    chk("rst_tready", s_tready, 0);
    chk("rst_start", ctrl_dataIn_enc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_frame, 0);
    chk("rst_data", enc_dataIn, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("tready_before_edge", s_tready, 0);
    @(negedge clk);
    chk("tready_after_release", s_tready, 1);
    @(posedge clk);
    #1;

    // Known block, start latency, and a done pulse during START that must be ignored
    send_word(32'h03020100, 1'b0);
    send_word(32'h07060504, 1'b0);
    send_word(32'h0B0A0908, 1'b0);
    send_word(32'h0F0E0D0C, 1'b1);
    @(negedge clk);
    chk("latency_cycle1", ctrl_dataIn_enc, 0);
    @(posedge clk);
    #1 man_done = 1'b1;
    @(negedge clk);
    chk("latency_cycle2", ctrl_dataIn_enc, 1);
    chk("known_block", enc_dataIn, known);
    @(posedge clk);
    #1 man_done = 1'b0;
    @(negedge clk);
    chk("done_in_start_ignored", busy, 1);
    @(posedge clk);
    #1 man_done = 1'b1;
    @(posedge clk);
    #1 man_done = 1'b0;
    @(negedge clk);
    chk("idle_after_done", busy, 0);

    // Done while idle and empty: no pop, next block still starts on time
    @(posedge clk);
    #1 man_done = 1'b1;
    @(posedge clk);
    #1 man_done = 1'b0;
    @(negedge clk);
    chk("idle_done_busy", busy, 0);
    chk("idle_done_tready", s_tready, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send_word($urandom, i == 3);
    @(negedge clk);
    chk("idle_done_lat1", ctrl_dataIn_enc, 0);
    @(negedge clk);
    chk("idle_done_lat2", ctrl_dataIn_enc, 1);
    @(posedge clk);
    #1 man_done = 1'b1;
    @(posedge clk);
    #1 man_done = 1'b0;

    // Short frame: tlast on word 1
    auto_en = 1'b1;
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b1);
    @(negedge clk);
    chk("short_err", err_frame, 1);
    repeat (4) begin
      @(negedge clk);
      chk("short_no_start", busy, 0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send_word($urandom, i == 3);
    drain(200);

    // Back-pressure with done held low, release on the done pulse
    auto_en = 1'b0;
    for (int i = 0; i < 8; i++) send_word($urandom, i == 3 || i == 7);
    s_tdata  = $urandom;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_stall", s_tready, 0);
    end
    @(posedge clk);
    #1;
    man_done = 1'b1;
    auto_en  = 1'b1;
    @(negedge clk);
    chk("ready_on_done", s_tready, 1);
    @(posedge clk);
    model_accept(s_tdata, 1'b0);
    #1;
    man_done = 1'b0;
    s_tvalid = 1'b0;
    for (int i = 0; i < 3; i++) send_word($urandom, i == 2);
    drain(400);

    // Reset while busy with both slots full
    auto_en = 1'b0;
    for (int i = 0; i < 8; i++) send_word($urandom, i == 3 || i == 7);
    @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_tready", s_tready, 0);
    chk("midrst_start", ctrl_dataIn_enc, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err_frame, 0);
    chk("midrst_data", enc_dataIn, 0);
    exp_q.delete();
    m_words.delete();
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_reset_idle", busy | ctrl_dataIn_enc, 0);
    end
    @(posedge clk);
    #1;

    // Randomized frames against the model
    auto_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) len = $urandom_range(1, 3);
      else if (kind == 1) len = 8;
      else if (kind == 2) len = $urandom_range(5, 7);
      else len = 4;
      for (int i = 0; i < len; i++) begin
        gap($urandom_range(0, 2));
        send_word($urandom, i == len - 1);
      end
      @(negedge clk);
      chk("err_track", err_frame, m_err);
      @(posedge clk);
      #1;
    end
    drain(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1);
  end

endmodule
